// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the unified memory-port
//                arbiter (state encoding, grant IDs, instruction width).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    localparam int INST_W = 32;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin picker. On a tie the requester that was
//                not granted last wins; otherwise the sole requester wins.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,       // [GNT_INST] = fetch, [GNT_DATA] = data
    input  logic       last,      // grant ID of the previous winner
    output logic       grant_id,
    output logic       any
);

    // Pick a winner: alternate on a tie, otherwise serve whoever is asking
    always_comb begin
        any      = |req;
        grant_id = GNT_INST;
        if (req == 2'b11) begin
            grant_id = ~last;
        end else if (req[GNT_DATA]) begin
            grant_id = GNT_DATA;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between instruction fetch and data
//                access. One transaction at a time over req/ack, round-robin
//                on ties, with a timeout abort against a silent memory.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,   // must be 64
    parameter int TIMEOUT = 255   // must be >= 1
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch requester
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_valid,
    output logic              inst_err,
    // data requester
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_valid,
    output logic              data_err,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    import mem_arb_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Value the counter holds on the busy edge that exhausts the budget
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             grant_id;
    logic             any_req;

    // Sub-word byte offsets never reach the memory port
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[1:0], data_addr[2:0]};

    rr_arbiter2 u_rr (
        .req      ({data_req, inst_req}),
        .last     (last_grant),
        .grant_id (grant_id),
        .any      (any_req)
    );

    // Transaction FSM: grant, wait for ack or timeout, one-cycle response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_INST;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_rdata <= '0;
            inst_valid <= 1'b0;
            inst_err   <= 1'b0;
            data_rdata <= '0;
            data_valid <= 1'b0;
            data_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_req    <= 1'b1;
                        last_grant <= grant_id;
                        cnt        <= '0;
                        if (grant_id == GNT_DATA) begin
                            mem_addr  <= {data_addr[ADDR_W-1:3], 3'b000};
                            mem_we    <= data_we;
                            mem_wdata <= data_wdata;
                            state     <= BUSY_D;
                        end else begin
                            mem_addr  <= {inst_addr[ADDR_W-1:3], 3'b000};
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            state     <= BUSY_I;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack always beats a coincident timeout
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (state == BUSY_I) begin
                            inst_valid <= 1'b1;
                            inst_err   <= 1'b0;
                            inst_rdata <= inst_addr[2] ? mem_rdata[63:32]
                                                       : mem_rdata[31:0];
                        end else begin
                            data_valid <= 1'b1;
                            data_err   <= 1'b0;
                            data_rdata <= mem_we ? '0 : mem_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (state == BUSY_I) begin
                            inst_valid <= 1'b1;
                            inst_err   <= 1'b1;
                            inst_rdata <= '1;
                        end else begin
                            data_valid <= 1'b1;
                            data_err   <= 1'b1;
                            data_rdata <= '1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    inst_valid <= 1'b0;
                    inst_err   <= 1'b0;
                    data_valid <= 1'b0;
                    data_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a behavioural
//                memory responder and a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [63:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_valid, inst_err;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [63:0] data_addr = '0;
    logic [63:0] data_wdata = '0;
    logic [63:0] data_rdata;
    logic        data_valid, data_err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [63:0] mem_store [logic [63:0]];
    logic [63:0] ref_mem   [logic [63:0]];
    int ack_lat = 1;       // ack is raised in this cycle of mem_req (1-based)
    int req_cycles = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_valid(inst_valid), .inst_err(inst_err),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_valid(data_valid), .data_err(data_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] default_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
    endfunction

    function automatic logic [63:0] ref_word(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return default_word(a);
    endfunction

    // Memory model: acks in the ack_lat-th cycle of a request window
    always @(negedge clk) begin
        if (mem_req && !rst) begin
            req_cycles = req_cycles + 1;
            if (req_cycles == ack_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_store[mem_addr] = mem_wdata;
                    mem_rdata = {$urandom, $urandom};
                end else begin
                    mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr]
                                                           : default_word(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
        end else begin
            req_cycles = 0;
            mem_ack    = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        inst_req = 1'b0; data_req = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({inst_valid, inst_err, inst_rdata, data_valid, data_err, data_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_resp: iv=%b ie=%b ird=%h dv=%b de=%b drd=%h, want all 0",
                     inst_valid, inst_err, inst_rdata, data_valid, data_err, data_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        mem_store[64'h1000] = 64'hAAAA_BBBB_1111_2222;
        ack_lat = 1;
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 64'h1004;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1000 || mem_we !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_issue: req=%b addr=%h we=%b iv=%b, want 1 1000 0 0",
                     mem_req, mem_addr, mem_we, inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_rdata !== 32'hAAAA_BBBB || inst_err !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_resp: iv=%b rdata=%h err=%b req=%b, want 1 aaaabbbb 0 0",
                     inst_valid, inst_rdata, inst_err, mem_req);
        end
        inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_pulse: iv=%b one cycle later, want 0", inst_valid);
        end
    endtask

    task automatic test_data_write();
        logic [63:0] wd;
        int rc, pulses, bad_hold;
        wd = 64'h0123_4567_89AB_CDEF;
        rc = 0; pulses = 0; bad_hold = 0;
        ack_lat = 3;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 64'h2000; data_wdata = wd;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req) begin
                rc++;
                if (mem_we !== 1'b1 || mem_wdata !== wd || mem_addr !== 64'h2000) bad_hold++;
            end
            if (data_valid) begin
                pulses++;
                checks++;
                if (data_rdata !== 64'h0 || data_err !== 1'b0) begin
                    failures++;
                    $display("FAIL write_resp: rdata=%h err=%b, want 0 0", data_rdata, data_err);
                end
                data_req = 1'b0;
            end
        end
        checks++;
        if (rc != 3 || pulses != 1 || bad_hold != 0) begin
            failures++;
            $display("FAIL write_window: req_cycles=%0d pulses=%0d unstable=%0d, want 3 1 0",
                     rc, pulses, bad_hold);
        end
        checks++;
        if (mem_store[64'h2000] !== wd) begin
            failures++;
            $display("FAIL write_mem: stored=%h, want %h", mem_store[64'h2000], wd);
        end
    endtask

    task automatic test_rr_order();
        logic [3:0] order;
        int ng, bad;
        bit prev, raise_i, raise_d;
        order = '0; ng = 0; bad = 0; prev = 0; raise_i = 0; raise_d = 0;
        do_reset();
        ack_lat = 1;
        inst_addr = 64'h3000; data_addr = 64'h4000; data_we = 1'b0;
        inst_req = 1'b1; data_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (raise_i) begin inst_req = 1'b1; raise_i = 0; end
            if (raise_d) begin data_req = 1'b1; raise_d = 0; end
            if (mem_req && !prev) begin
                if (ng < 4) order[ng] = (mem_addr == 64'h4000);
                ng++;
            end
            prev = mem_req;
            if ((inst_valid || data_valid) && mem_req) bad++;
            if (inst_valid && data_valid) bad++;
            if (inst_valid) begin inst_req = 1'b0; raise_i = (ng < 3); end
            if (data_valid) begin data_req = 1'b0; raise_d = (ng < 3); end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] !== ((k % 2) == 0)) begin
                failures++;
                $display("FAIL rr_grant%0d: data=%b, want %b", k, order[k], (k % 2) == 0);
            end
        end
        checks++;
        if (ng != 4 || bad != 0) begin
            failures++;
            $display("FAIL rr_overlap: grants=%0d overlaps=%0d, want 4 0", ng, bad);
        end
    endtask

    task automatic test_timeout();
        int rc, pulses;
        rc = 0; pulses = 0;
        ack_lat = 99;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = 64'h500C;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req) rc++;
            if (data_valid) begin
                pulses++;
                checks++;
                if (data_err !== 1'b1 || data_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                    failures++;
                    $display("FAIL tmo_resp: err=%b rdata=%h, want 1 ffffffffffffffff",
                             data_err, data_rdata);
                end
                data_req = 1'b0;
            end
        end
        checks++;
        if (rc != TMO || pulses != 1) begin
            failures++;
            $display("FAIL tmo_window: req_cycles=%0d pulses=%0d, want %0d 1", rc, pulses, TMO);
        end
        // recovery: the next request completes normally
        ack_lat = 1; pulses = 0;
        data_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (data_valid) begin
                pulses++;
                checks++;
                if (data_err !== 1'b0 || data_rdata !== default_word(64'h5008)) begin
                    failures++;
                    $display("FAIL tmo_recover: err=%b rdata=%h, want 0 %h",
                             data_err, data_rdata, default_word(64'h5008));
                end
                data_req = 1'b0;
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL tmo_recover_pulse: pulses=%0d, want 1", pulses);
        end
    endtask

    task automatic test_ack_at_timeout();
        int rc, pulses;
        rc = 0; pulses = 0;
        ack_lat = TMO;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = 64'hA000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req) rc++;
            if (data_valid) begin
                pulses++;
                checks++;
                if (data_err !== 1'b0 || data_rdata !== default_word(64'hA000)) begin
                    failures++;
                    $display("FAIL ack_at_tmo: err=%b rdata=%h, want 0 %h",
                             data_err, data_rdata, default_word(64'hA000));
                end
                data_req = 1'b0;
            end
        end
        checks++;
        if (rc != TMO || pulses != 1) begin
            failures++;
            $display("FAIL ack_at_tmo_window: req_cycles=%0d pulses=%0d, want %0d 1", rc, pulses, TMO);
        end
    endtask

    task automatic test_reset_mid();
        int idone, ddone;
        idone = 0; ddone = 0;
        ack_lat = 99;
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 64'h6000; data_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h6000) begin
            failures++;
            $display("FAIL midrst_pre: req=%b addr=%h, want 1 6000", mem_req, mem_addr);
        end
        data_req = 1'b1; data_we = 1'b0; data_addr = 64'h7000;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, inst_valid, inst_err, inst_rdata,
             data_valid, data_err, data_rdata} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: req=%b addr=%h iv=%b dv=%b, want all 0",
                     mem_req, mem_addr, inst_valid, data_valid);
        end
        @(negedge clk);
        rst = 1'b0; ack_lat = 1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h7000) begin
            failures++;
            $display("FAIL midrst_first: req=%b addr=%h, want 1 7000", mem_req, mem_addr);
        end
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (inst_valid) begin idone++; inst_req = 1'b0; end
            if (data_valid) begin ddone++; data_req = 1'b0; end
        end
        checks++;
        if (idone != 1 || ddone != 1) begin
            failures++;
            $display("FAIL midrst_drain: inst=%0d data=%0d, want 1 1", idone, ddone);
        end
    endtask

    task automatic test_random();
        logic        last_w, first_w, nxt, dwe, prev;
        logic [63:0] ia, da, dwd, exp_addr, exp_wd, w, exp64;
        logic [31:0] exp32;
        int          mode, lat, need, done_n;
        bit          tmo, i_pend, d_pend;
        do_reset();
        last_w = 1'b0;
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            ia   = 64'h8000 + (64'($urandom_range(0, 15)) << 2);
            da   = 64'h8000 + 64'($urandom_range(0, 63));
            dwe  = 1'($urandom_range(0, 1));
            dwd  = {$urandom, $urandom};
            lat  = $urandom_range(1, 6);
            tmo  = (lat > TMO);
            i_pend = (mode != 1);
            d_pend = (mode != 0);
            need   = int'(i_pend) + int'(d_pend);
            first_w = (mode == 2) ? ~last_w : (mode == 1);
            nxt = first_w; prev = 1'b0; done_n = 0;
            ack_lat = lat;
            inst_addr = ia; data_addr = da; data_we = dwe; data_wdata = dwd;
            inst_req = i_pend; data_req = d_pend;
            for (int c = 0; c < 30 && done_n < need; c++) begin
                @(negedge clk);
                if (mem_req && !prev) begin
                    exp_addr = nxt ? {da[63:3], 3'b000} : {ia[63:3], 3'b000};
                    exp_wd   = nxt ? dwd : 64'h0;
                    checks++;
                    if (mem_addr !== exp_addr || mem_we !== (nxt & dwe) || mem_wdata !== exp_wd) begin
                        failures++;
                        $display("FAIL rnd_issue it=%0d: addr=%h we=%b wd=%h, want %h %b %h",
                                 it, mem_addr, mem_we, mem_wdata, exp_addr, nxt & dwe, exp_wd);
                    end
                end
                prev = mem_req;
                if (inst_valid || data_valid) begin
                    checks++;
                    if ({data_valid, inst_valid} !== (nxt ? 2'b10 : 2'b01)) begin
                        failures++;
                        $display("FAIL rnd_owner it=%0d: dv=%b iv=%b, want data=%b",
                                 it, data_valid, inst_valid, nxt);
                    end
                    if (inst_valid) begin
                        w = tmo ? 64'hFFFF_FFFF_FFFF_FFFF : ref_word({ia[63:3], 3'b000});
                        exp32 = ia[2] ? w[63:32] : w[31:0];
                        checks++;
                        if (inst_rdata !== exp32 || inst_err !== tmo) begin
                            failures++;
                            $display("FAIL rnd_inst it=%0d: rdata=%h err=%b, want %h %b",
                                     it, inst_rdata, inst_err, exp32, tmo);
                        end
                        inst_req = 1'b0;
                    end
                    if (data_valid) begin
                        exp64 = tmo ? 64'hFFFF_FFFF_FFFF_FFFF
                                    : (dwe ? 64'h0 : ref_word({da[63:3], 3'b000}));
                        checks++;
                        if (data_rdata !== exp64 || data_err !== tmo) begin
                            failures++;
                            $display("FAIL rnd_data it=%0d: rdata=%h err=%b, want %h %b",
                                     it, data_rdata, data_err, exp64, tmo);
                        end
                        if (dwe && !tmo) ref_mem[{da[63:3], 3'b000}] = dwd;
                        data_req = 1'b0;
                    end
                    last_w = nxt;
                    nxt    = ~nxt;
                    done_n++;
                end
            end
            checks++;
            if (done_n != need) begin
                failures++;
                $display("FAIL rnd_budget it=%0d: completed=%0d, want %0d", it, done_n, need);
                inst_req = 1'b0; data_req = 1'b0;
                do_reset();
                last_w = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_rr_order();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
